mdu_iter: RTL and testbench

- Parametrised successor to the pipeline's multiply/divide unit, instantiated in EX alongside the ALU.
- Owns architectural HI/LO and executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO; serves MFHI/MFLO combinationally.
- Multiply uses a single-cycle product retired after a configurable delay; divide is a true iterative radix-2 restoring divider (one quotient bit per cycle).
- Adds cancel (exception flush), a done pulse, and defined divide-by-zero/overflow results.

---
 rtl/mdu_iter_pkg.sv | 40 ++++
 rtl/mdu_div_core.sv | 58 +++++
 rtl/mdu_iter.sv | 184 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared constants and helpers for the iterative multiply/divide unit.
// Op encodings are driven by the EX-stage decoder.
package mdu_iter_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;
    localparam logic [3:0] MDU_MSUB  = 4'd6;
    localparam logic [3:0] MDU_MSUBU = 4'd7;
    localparam logic [3:0] MDU_MTHI  = 4'd8;
    localparam logic [3:0] MDU_MTLO  = 4'd9;
    localparam logic [3:0] MDU_MFHI  = 4'd10;
    localparam logic [3:0] MDU_MFLO  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_RUN,
        ST_DIV_FIX
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDU_MULT)  || (op == MDU_MULTU) ||
               (op == MDU_MADD)  || (op == MDU_MADDU) ||
               (op == MDU_MSUB)  || (op == MDU_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mul_signed(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MADD) ||
               (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step.
// Operands are unsigned magnitudes; sign fix-up lives in mdu_iter.
module mdu_div_core
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The quotient register doubles as the dividend shift-out register.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        diff    = shifted[WIDTH-1:0] - dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = ge ? diff : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// EX-stage multiply/divide unit owning HI/LO: delayed multiply,
// iterative restoring divide, cancel on flush, done pulse on write.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [3:0]         op_q, op_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    logic [2*WIDTH-1:0] mul_res;
    logic               div_sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               div_load, div_step;
    logic [WIDTH-1:0]   quotient, remainder;

    always_comb begin
        a_ext = mul_signed(op) ? {{WIDTH{rs[WIDTH-1]}}, rs}
                               : {{WIDTH{1'b0}}, rs};
        b_ext = mul_signed(op) ? {{WIDTH{rt[WIDTH-1]}}, rt}
                               : {{WIDTH{1'b0}}, rt};
        product = a_ext * b_ext;
        div_sgn = (op == MDU_DIV);
        a_abs   = (div_sgn && rs[WIDTH-1]) ? -rs : rs;
        b_abs   = (div_sgn && rt[WIDTH-1]) ? -rt : rt;
    end

    always_comb begin
        mul_res = prod_q;
        if ((op_q == MDU_MADD) || (op_q == MDU_MADDU))
            mul_res = {hi_q, lo_q} + prod_q;
        else if ((op_q == MDU_MSUB) || (op_q == MDU_MSUBU))
            mul_res = {hi_q, lo_q} - prod_q;
    end

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quotient (quotient),
        .remainder(remainder)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod_d   = prod_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        (op == MDU_MTHI): hi_d = rs;
                        (op == MDU_MTLO): lo_d = rs;
                        is_mul_op(op): begin
                            prod_d  = product;
                            op_d    = op;
                            cnt_d   = CNT_W'(MUL_LAT);
                            state_d = ST_MUL_WAIT;
                        end
                        is_div_op(op): begin
                            div_load = 1'b1;
                            op_d     = op;
                            qneg_d   = div_sgn &&
                                       (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            rneg_d   = div_sgn && rs[WIDTH-1];
                            dz_d     = (rt == '0);
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = ST_DIV_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_DIV_RUN: begin
                div_step = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                lo_d    = dz_q   ? '1 :
                          qneg_q ? -quotient : quotient;
                hi_d    = rneg_q ? -remainder : remainder;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush beats both a same-cycle start and a completion.
        if (cancel) begin
            state_d  = ST_IDLE;
            hi_d     = hi_q;
            lo_d     = lo_q;
            prod_d   = prod_q;
            op_d     = op_q;
            qneg_d   = qneg_q;
            rneg_d   = rneg_q;
            dz_d     = dz_q;
            cnt_d    = cnt_q;
            done_d   = 1'b0;
            div_load = 1'b0;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign rd_data = (op == MDU_MFHI) ? hi_q :
                     (op == MDU_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: multiply/accumulate, divide corners,
// cancel, start-while-busy and mid-operation reset.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;

    int vecs = 0;
    int miss = 0;

    mdu_iter #(
        .WIDTH  (32),
        .MUL_LAT(5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .busy   (busy),
        .done   (done),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] eh,
                            input logic [31:0] el);
        op = MDU_MFHI;
        #1 chk({tag, "_hi"}, rd_data, eh);
        op = MDU_MFLO;
        #1 chk({tag, "_lo"}, rd_data, el);
        op = MDU_MFHI;
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; rs = v;
        @(negedge clk);
        start = 1'b0; op = MDU_MFHI;
        chk("mt_busy", {31'd0, busy}, 32'd0);
    endtask

    // inj > 0 issues a MULT on that busy cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input int inj,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        int d;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = MDU_MFHI;
        n = 0; d = 0;
        while (busy && n < 200) begin
            n++;
            if (done) d++;
            if (n == inj) begin
                start = 1'b1; op = MDU_MULT; rs = 32'd2; rt = 32'd3;
            end else begin
                start = 1'b0; op = MDU_MFHI;
            end
            @(negedge clk);
        end
        start = 1'b0; op = MDU_MFHI;
        if (done) d++;
        @(negedge clk);
        if (done) d++;
        chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
        chk({tag, "_done"}, 32'(d), 32'd1);
        chk_hilo(tag, eh, el);
    endtask

    initial begin
        int d;
        reset = 1'b1; start = 1'b0; cancel = 1'b0;
        op = MDU_MFHI; rs = '0; rt = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_hilo("rst", 32'h0, 32'h0);

        run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, 0,
               32'hFFFFFFFF, 32'hFFFFFFFA);
        op = MDU_DIV;
        #1 chk("rd_other", rd_data, 32'h0);

        mt(MDU_MTHI, 32'h0);
        mt(MDU_MTLO, 32'hFFFFFFFF);
        chk_hilo("mt", 32'h0, 32'hFFFFFFFF);
        run_op("maddu", MDU_MADDU, 32'd1, 32'd1, 5, 0,
               32'h1, 32'h0);
        run_op("msub", MDU_MSUB, 32'd2, 32'd3, 5, 0,
               32'h0, 32'hFFFFFFFA);

        run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 33, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", MDU_DIVU, 32'd100, 32'd7, 33, 0,
               32'd2, 32'd14);
        run_op("div0", MDU_DIVU, 32'h1234, 32'h0, 33, 0,
               32'h1234, 32'hFFFFFFFF);
        run_op("ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 0,
               32'h0, 32'h80000000);

        @(negedge clk);
        start = 1'b1; op = MDU_DIV; rs = 32'd100; rt = 32'd7;
        @(negedge clk);
        start = 1'b0; op = MDU_MFHI;
        repeat (9) @(negedge clk);
        chk("cxl_pre_busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cxl_busy", {31'd0, busy}, 32'd0);
        d = 0;
        repeat (40) begin
            if (done) d++;
            @(negedge clk);
        end
        chk("cxl_done", 32'(d), 32'd0);
        chk_hilo("cxl", 32'h0, 32'h80000000);

        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = MDU_MTLO; rs = 32'hDEAD;
        @(negedge clk);
        op = MDU_MULT; rs = 32'd5; rt = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = MDU_MFHI;
        chk("sc_busy", {31'd0, busy}, 32'd0);
        d = 0;
        repeat (10) begin
            if (done) d++;
            @(negedge clk);
        end
        chk("sc_done", 32'(d), 32'd0);
        chk_hilo("sc", 32'h0, 32'h80000000);

        run_op("inj", MDU_DIVU, 32'd100, 32'd7, 33, 5,
               32'd2, 32'd14);

        @(negedge clk);
        start = 1'b1; op = MDU_DIV; rs = 32'hFFFFFFF9; rt = 32'd2;
        @(negedge clk);
        start = 1'b0; op = MDU_MFHI;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk_hilo("mrst", 32'h0, 32'h0);
        d = 0;
        repeat (40) begin
            if (done) d++;
            @(negedge clk);
        end
        chk("mrst_done", 32'(d), 32'd0);

        run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0,
               32'hFFFFFFFE, 32'h00000001);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miss);
        $finish;
    end

endmodule
